// File: rtl/lfsr_code_gen_if.sv
// ============================================================================
// lfsr_code_gen_if : control/observation bundle for the LFSR code generator
// Rev 1.0
// ============================================================================
`default_nettype none

interface lfsr_code_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             load_enable;
  logic             shift_enable;
  logic [WIDTH-1:0] seed;
  logic             Q;
  logic [WIDTH-1:0] state;

  modport master (
    output load_enable,
    output shift_enable,
    output seed,
    input  Q,
    input  state
  );

  modport slave (
    input  load_enable,
    input  shift_enable,
    input  seed,
    output Q,
    output state
  );
endinterface

`default_nettype wire

// File: rtl/lfsr_code_gen.sv
// ============================================================================
// lfsr_code_gen : loadable Fibonacci LFSR, left-shifting, MSB on serial output
// Rev 1.0
// ============================================================================
`default_nettype none

module lfsr_code_gen #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = 32'h80200003,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h00000001
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  lfsr_code_gen_if.slave bus
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             w_fb;

  // An all-zero seed would lock the register up, so it is replaced.
  always_comb begin
    w_fb    = ^(state_q & TAPS);
    state_d = state_q;
    if (bus.load_enable) begin
      state_d = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
    end else if (bus.shift_enable) begin
      state_d = {state_q[WIDTH-2:0], w_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.state = state_q;
  assign bus.Q     = state_q[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_lfsr_code_gen.sv
// ============================================================================
// tb_lfsr_code_gen : scoreboard bench for 32-bit and 4-bit LFSR instances
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lfsr_code_gen;

  localparam logic [31:0] TAPS32 = 32'h80200003;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_code_gen_if #(.WIDTH(32)) bus32 ();
  lfsr_code_gen_if #(.WIDTH(4))  bus4 ();

  lfsr_code_gen #(.WIDTH(32), .TAPS(32'h80200003), .DEFAULT_SEED(32'h00000001)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus32.slave)
  );

  lfsr_code_gen #(.WIDTH(4), .TAPS(4'hC), .DEFAULT_SEED(4'h1)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  typedef struct {
    logic [31:0] state;
    logic        q;
    string       tag;
    int          idx;
  } exp32_t;

  typedef struct {
    logic [3:0] state;
    logic       first;
    string      tag;
    int         idx;
  } exp4_t;

  exp32_t sb32[$];
  exp4_t  sb4[$];

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] next32(input logic [31:0] s);
    return {s[30:0], ^(s & TAPS32)};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon32
    exp32_t e;
    if (sb32.size() > 0) begin
      e = sb32.pop_front();
      vectors++;
      if (bus32.state !== e.state || bus32.Q !== e.q || bus32.state == 32'h0) begin
        miscompares++;
        $display("FAIL %s[%0d]: got state=%h Q=%b, expected state=%h Q=%b",
                 e.tag, e.idx, bus32.state, bus32.Q, e.state, e.q);
      end
    end
  end

  logic [15:0] seen4;
  always @(negedge clk) begin : mon4
    exp4_t e;
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      vectors++;
      if (e.first) seen4 = '0;
      if (bus4.state !== e.state || bus4.Q !== e.state[3] ||
          (!e.first && seen4[bus4.state])) begin
        miscompares++;
        $display("FAIL %s[%0d]: got state=%h Q=%b, expected state=%h Q=%b (distinct)",
                 e.tag, e.idx, bus4.state, bus4.Q, e.state, e.state[3]);
      end
      if (!e.first) seen4[bus4.state] = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc32(input logic r, input logic ld, input logic sh, input logic [31:0] sd);
    rst_n              = r;
    bus32.load_enable  = ld;
    bus32.shift_enable = sh;
    bus32.seed         = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc4(input logic ld, input logic sh, input logic [3:0] sd);
    bus4.load_enable  = ld;
    bus4.shift_enable = sh;
    bus4.seed         = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic exp32(input logic [31:0] s, input logic q, input string tag, input int idx);
    exp32_t e;
    e.state = s; e.q = q; e.tag = tag; e.idx = idx;
    sb32.push_back(e);
  endtask

  task automatic exp4(input logic [3:0] s, input logic first, input string tag, input int idx);
    exp4_t e;
    e.state = s; e.first = first; e.tag = tag; e.idx = idx;
    sb4.push_back(e);
  endtask

  logic [31:0] model;
  logic [31:0] q_table;
  logic [3:0]  seq4 [15];
  logic        qexp;

  initial begin
    // Q after shift k from seed 0x3039 is original bit 31-k.
    q_table = 32'h9C0C0000;
    seq4 = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    bus4.load_enable  = 1'b0;
    bus4.shift_enable = 1'b0;
    bus4.seed         = 4'h0;

    // reset, then hold
    for (int i = 0; i < 2; i++) begin
      cyc32(1'b0, 1'b0, 1'b0, 32'h0);
      exp32(32'h00000001, 1'b0, "reset", i);
    end
    for (int i = 0; i < 5; i++) begin
      cyc32(1'b1, 1'b0, 1'b0, 32'h0);
      exp32(32'h00000001, 1'b0, "hold", i);
    end

    // seed 0x3039, then 200 shifts
    cyc32(1'b1, 1'b1, 1'b0, 32'h00003039);
    exp32(32'h00003039, 1'b0, "load3039", 0);
    model = 32'h00003039;
    for (int k = 1; k <= 200; k++) begin
      cyc32(1'b1, 1'b0, 1'b1, 32'h0);
      model = next32(model);
      qexp  = (k <= 31) ? q_table[k] : model[31];
      exp32(model, qexp, "shift3039", k);
    end

    // load beats shift
    cyc32(1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    exp32(32'hDEADBEEF, 1'b1, "load_and_shift", 0);

    // zero seed replaced, then 1000 shifts never reach zero
    cyc32(1'b1, 1'b1, 1'b0, 32'h0);
    exp32(32'h00000001, 1'b0, "zero_seed", 0);
    model = 32'h00000001;
    for (int k = 1; k <= 1000; k++) begin
      cyc32(1'b1, 1'b0, 1'b1, 32'h0);
      model = next32(model);
      exp32(model, model[31], "long_run", k);
    end

    // mid-sequence reset; TAPS bit 0 makes the first step from 1 go to 3
    for (int k = 1; k <= 50; k++) begin
      cyc32(1'b1, 1'b0, 1'b1, 32'h0);
      model = next32(model);
      exp32(model, model[31], "pre_reset", k);
    end
    cyc32(1'b0, 1'b0, 1'b1, 32'h0);
    exp32(32'h00000001, 1'b0, "mid_reset", 0);
    cyc32(1'b1, 1'b0, 1'b1, 32'h0);
    exp32(32'h00000003, 1'b0, "post_reset_shift", 0);
    cyc32(1'b1, 1'b0, 1'b0, 32'h0);
    exp32(32'h00000003, 1'b0, "post_reset_hold", 0);

    // 4-bit maximal sequence
    cyc4(1'b1, 1'b0, 4'h1);
    exp4(4'h1, 1'b1, "w4_load", 0);
    for (int k = 1; k <= 15; k++) begin
      cyc4(1'b0, 1'b1, 4'h0);
      exp4(seq4[k-1], 1'b0, "w4_shift", k);
    end
    cyc4(1'b0, 1'b0, 4'h0);

    repeat (4) @(posedge clk);
    if (sb32.size() != 0 || sb4.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0", sb32.size(), sb4.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
